// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: port A reads imem_addr, port B reads imem_addr+1, both combinational.
interface instruction_fetch_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 16;

    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_data;
    logic [WORD_W-1:0] imem_data_next;

    modport master (output imem_addr, input imem_data, input imem_data_next);
    modport slave  (input imem_addr, output imem_data, output imem_data_next);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, reset/interrupt vector loads, two-word instructions, branch, stall, interrupt bubble.
// Optional FETCH_PERF_COUNT_EN adds fetch and stall counters.
module instruction_fetch #(
    parameter int unsigned IMM_FLAG_BIT   = 15,
    parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
    parameter logic [31:0] INT_VEC_ADDR   = 32'd2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    input  logic                int_req,
    instruction_fetch_if.master imem,
    output logic [31:0]         PC_out,
    output logic [15:0]         instruction_out,
    output logic [15:0]         Data_out,
    output logic                INT_out
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]         fetch_count_out,
    output logic [31:0]         stall_count_out
`endif
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        INT_EMIT = 2'd2,
        INT_VEC  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              int_pending;

    logic              imm_flag;
    logic [ADDR_W-1:0] vec_word;
    logic [ADDR_W-1:0] pc_step;
    logic              seq_advance;

    assign imm_flag    = imem.imem_data[IMM_FLAG_BIT];
    assign vec_word    = {imem.imem_data, imem.imem_data_next};
    assign pc_step     = imm_flag ? ADDR_W'(2) : ADDR_W'(1);
    assign seq_advance = (state == RUN) && !branch_taken && !stall && !int_pending;

    // State, PC and pending-interrupt register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= '0;
            int_pending <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    pc    <= vec_word;
                    state <= RUN;
                end
                RUN: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (int_pending) begin
                        state <= INT_EMIT;
                    end else begin
                        pc <= pc + pc_step;
                    end
                end
                INT_EMIT: begin
                    // A branch here retargets the return address and keeps the marker pending
                    if (branch_taken) begin
                        pc <= branch_target;
                    end else if (!stall) begin
                        int_pending <= 1'b0;
                        state       <= INT_VEC;
                    end
                end
                INT_VEC: begin
                    if (!stall) begin
                        pc    <= vec_word;
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
            // New requests win over the clear so they are serviced after returning to RUN
            if (int_req) begin
                int_pending <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_out <= '0;
            stall_count_out <= '0;
        end else begin
            if (seq_advance) begin
                fetch_count_out <= fetch_count_out + 32'd1;
            end
            if (stall && (state != BOOT)) begin
                stall_count_out <= stall_count_out + 32'd1;
            end
        end
    end
`endif

    // Memory address and IF/ID outputs, forced to NOP while reset is held
    always_comb begin
        imem.imem_addr  = pc;
        PC_out          = '0;
        instruction_out = '0;
        Data_out        = '0;
        INT_out         = 1'b0;
        if (!reset) begin
            case (state)
                BOOT: begin
                    imem.imem_addr = RESET_VEC_ADDR;
                end
                RUN: begin
                    PC_out          = pc;
                    instruction_out = imem.imem_data;
                    Data_out        = imm_flag ? imem.imem_data_next : WORD_W'(0);
                end
                INT_EMIT: begin
                    PC_out  = pc;
                    INT_out = 1'b1;
                end
                INT_VEC: begin
                    imem.imem_addr = INT_VEC_ADDR;
                end
                default: begin
                    imem.imem_addr = pc;
                end
            endcase
        end else begin
            imem.imem_addr = RESET_VEC_ADDR;
        end
    end
endmodule
